wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Owns the single register-file write port after the WB mux. Arbitrates between the in-order pipeline
//  write-back (rd + Write_data from the WB stage) and a long-latency unit (mul/div, MDU) that returns
//  out of step. Holds one MDU result in a buffer, bounds its wait with a starvation counter, stalls
//  the pipeline when it must, and drives registered RF write signals. Sits between WB and the regfile.
// PARAMETERS
//  STARVE_LIMIT  4   cycles a buffered MDU result may lose to the pipeline before it is forced (>=1)
//  CNT_W         3   width of starvation counter; must hold STARVE_LIMIT
// PORTS
//  clk          in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  pipe_valid   in   1   WB stage has a register write this cycle (RegWrite & valid)
//  pipe_rd      in   5   WB destination register
//  pipe_wdata   in   32  WB write data (output of the WB mux)
//  pipe_stall   out  1   hold WB and everything upstream this cycle
//  mdu_valid    in   1   MDU result available
//  mdu_ready    out  1   buffer can accept an MDU result
//  mdu_rd       in   5   MDU destination register
//  mdu_wdata    in   32  MDU result
//  rf_we        out  1   regfile write enable (registered)
//  rf_waddr     out  5   regfile write address (registered)
//  rf_wdata     out  32  regfile write data (registered)
// BEHAVIOUR
//  Clock clk; reset rst_n asynchronous, active-low. Reset clears buffer, counter, state, all outputs:
//   rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, mdu_ready=1. Reset mid-transfer discards buffer.
//  Buffer: 1 entry {buf_v, buf_rd, buf_data}. mdu_ready = !buf_v | grant_buf (combinational).
//   Capture on mdu_valid & mdu_ready; MDU must hold mdu_rd/mdu_wdata while mdu_valid & !mdu_ready.
//  FSM (2 states):
//   PIPE_PRI : pipe_valid -> grant_pipe; else buf_v -> grant_buf. If buf_v & grant_pipe, cnt++;
//              cnt==STARVE_LIMIT-1 on such a cycle -> FORCE next cycle.
//   FORCE    : grant_buf unconditionally; pipe_stall = pipe_valid; cnt<=0; -> PIPE_PRI next cycle.
//   cnt clears whenever grant_buf or buf_v=0.
//  pipe_stall is combinational, asserted only in FORCE with pipe_valid=1; WB holds inputs stable.
//  Kill rule: buffered MDU result is older than the WB instruction. If grant_pipe & buf_v &
//   buf_rd==pipe_rd, buf_v clears same edge (WAW, younger wins); no write for the buffer entry.
//   Same rule against an MDU result captured that cycle does not apply (MDU result is newer-issued
//   only if hazard unit allowed it; it is written normally).
//  Simultaneous capture and grant_buf: buffer releases old entry and loads new one same edge.
//  Output register: edge after a grant, rf_we<=1 unless granted rd==0 (x0: rf_we<=0, grant still
//   consumed); rf_waddr/rf_wdata load granted rd/data. No grant -> rf_we<=0, addr/data hold.
//  Latency: grant to rf_we = 1 cycle. Max MDU wait after capture = STARVE_LIMIT+1 cycles.
// CONFIGURATION
//  WB_ARB_PERF_EN defined: adds outputs perf_stall_cnt[31:0] (cycles pipe_stall=1) and
//   perf_kill_cnt[15:0] (buffer entries killed); both reset to 0, saturate at all-ones.
//  Not defined: ports and counters absent; arbitration behaviour identical.
// TESTING
//  1 Reset: rst_n=0 async mid-cycle -> rf_we=0, pipe_stall=0, mdu_ready=1 immediately.
//  2 Pipe only: pipe_valid=1 rd=5 data=0x1234 -> next edge rf_we=1 waddr=5 wdata=0x1234.
//  3 MDU idle port: mdu_valid rd=7 0xCAFE, pipe_valid=0 -> captured, granted next cycle,
//    rf_we=1 waddr=7 two edges after capture; mdu_ready=1 throughout.
//  4 Starvation: buffer rd=9, pipe_valid=1 every cycle, STARVE_LIMIT=4 -> 4 pipe writes, then one
//    cycle pipe_stall=1 with rf write of rd=9, then pipe resumes with its held rd/data.
//  5 Kill: buffer rd=3 0xAAAA, pipe writes rd=3 0xBBBB -> only 0xBBBB written, buf_v=0, mdu_ready=1.
//  6 x0: pipe rd=0 data=0xFFFF -> rf_we stays 0; MDU rd=0 likewise, buffer still drains.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Owns the single register-file write port after the WB mux. The in-order
//   pipeline write-back normally wins the port. A long-latency unit (MDU)
//   returns results out of step; one such result is parked in a single-entry
//   buffer until the port is free. A starvation counter bounds how long the
//   buffered result can keep losing: once it has lost STARVE_LIMIT times, the
//   next cycle is reserved for it and the pipeline is stalled if it also
//   wants to write.
//
//   Optional build macro: WB_ARB_PERF_EN adds saturating performance counters
//   perf_stall_cnt (cycles with pipe_stall=1) and perf_kill_cnt (buffer
//   entries killed by a younger write to the same register).
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   pipe_valid      WB stage has a register write this cycle
//   pipe_rd         WB destination register
//   pipe_wdata      WB write data
//   pipe_stall      hold WB and everything upstream this cycle
//   mdu_valid       MDU result available
//   mdu_ready       buffer can accept an MDU result this cycle
//   mdu_rd          MDU destination register
//   mdu_wdata       MDU result
//   rf_we           registered regfile write enable
//   rf_waddr        registered regfile write address
//   rf_wdata        registered regfile write data
//   perf_stall_cnt  (WB_ARB_PERF_EN only) stall cycle count, saturating
//   perf_kill_cnt   (WB_ARB_PERF_EN only) killed buffer entry count, saturating

module wb_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pipe_valid,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_wdata,
   output logic        pipe_stall,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_wdata,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
`ifdef WB_ARB_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [15:0] perf_kill_cnt
`endif
);

   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(STARVE_LIMIT - 1);

   typedef enum logic {
      PIPE_PRI = 1'b0,
      FORCE    = 1'b1
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;

   logic               buf_v;
   logic [4:0]         buf_rd;
   logic [31:0]        buf_data;

   logic               grant_pipe;
   logic               grant_buf;
   logic               kill;
   logic               capture;

   // Arbitration and starvation tracking
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      grant_pipe = 1'b0;
      grant_buf  = 1'b0;
      pipe_stall = 1'b0;
      kill       = 1'b0;

      case (state_q)
         PIPE_PRI: begin
            grant_pipe = pipe_valid;
            grant_buf  = !pipe_valid && buf_v;
         end
         FORCE: begin
            grant_buf  = buf_v;
            pipe_stall = pipe_valid;
            state_d    = PIPE_PRI;
         end
         default: state_d = PIPE_PRI;
      endcase

      // The buffered MDU result is older than the WB instruction, so a WB
      // write to the same register makes it dead (WAW, younger wins).
      kill = grant_pipe && buf_v && (buf_rd == pipe_rd);

      if (!buf_v || grant_buf || kill || (state_q == FORCE)) begin
         cnt_d = '0;
      end else if (grant_pipe) begin
         cnt_d = cnt_q + CNT_W'(1);
         // Only a surviving entry forces; a killed one has nothing to write.
         if (cnt_q == LIMIT_M1) begin
            state_d = FORCE;
         end
      end
   end

   // A releasing entry frees the slot in the same cycle, so a new result can
   // be loaded on the edge that writes the old one.
   assign mdu_ready = !buf_v || grant_buf;
   assign capture   = mdu_valid && mdu_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= PIPE_PRI;
         cnt_q    <= '0;
         buf_v    <= 1'b0;
         buf_rd   <= '0;
         buf_data <= '0;
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;

         if (capture) begin
            buf_v    <= 1'b1;
            buf_rd   <= mdu_rd;
            buf_data <= mdu_wdata;
         end else if (grant_buf || kill) begin
            buf_v    <= 1'b0;
         end

         // Writes to x0 still consume the grant but never reach the regfile.
         if (grant_pipe) begin
            rf_we    <= (pipe_rd != 5'd0);
            rf_waddr <= pipe_rd;
            rf_wdata <= pipe_wdata;
         end else if (grant_buf) begin
            rf_we    <= (buf_rd != 5'd0);
            rf_waddr <= buf_rd;
            rf_wdata <= buf_data;
         end else begin
            rf_we    <= 1'b0;
         end
      end
   end

`ifdef WB_ARB_PERF_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_kill_cnt  <= '0;
      end else begin
         if (pipe_stall) begin
            perf_stall_cnt <= sat_inc32(perf_stall_cnt);
         end
         if (kill) begin
            perf_kill_cnt <= sat_inc16(perf_kill_cnt);
         end
      end
   end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   localparam int STARVE_LIMIT = 4;
   localparam int N_RANDOM     = 3000;

   logic        clk;
   logic        rst_n;
   logic        pipe_valid;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_wdata;
   logic        pipe_stall;
   logic        mdu_valid;
   logic        mdu_ready;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_wdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
`ifdef WB_ARB_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [15:0] perf_kill_cnt;
`endif

   wb_port_arbiter #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pipe_valid (pipe_valid),
      .pipe_rd    (pipe_rd),
      .pipe_wdata (pipe_wdata),
      .pipe_stall (pipe_stall),
      .mdu_valid  (mdu_valid),
      .mdu_ready  (mdu_ready),
      .mdu_rd     (mdu_rd),
      .mdu_wdata  (mdu_wdata),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata)
`ifdef WB_ARB_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_kill_cnt  (perf_kill_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Directed vectors: inputs for one cycle, the combinational outputs
   // expected during that cycle, and the registered outputs after its edge.
   typedef struct {
      logic        pv;
      logic [4:0]  prd;
      logic [31:0] pd;
      logic        mv;
      logic [4:0]  mrd;
      logic [31:0] md;
      logic        e_stall;
      logic        e_ready;
      logic        e_we;
      logic [4:0]  e_waddr;
      logic [31:0] e_wdata;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                      input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                      input logic es, input logic er,
                      input logic ew, input logic [4:0] ea, input logic [31:0] ed);
      vec_t v;
      v.pv = pv; v.prd = prd; v.pd = pd;
      v.mv = mv; v.mrd = mrd; v.md = md;
      v.e_stall = es; v.e_ready = er;
      v.e_we = ew; v.e_waddr = ea; v.e_wdata = ed;
      tbl.push_back(v);
   endtask

   // Behavioural reference: a parked MDU result remembers how many times it
   // has been passed over; after STARVE_LIMIT losses it owns the next cycle.
   bit          m_bv;
   logic [4:0]  m_brd;
   logic [31:0] m_bd;
   int          m_loss;
   bit          m_force;
   logic        m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   int          m_win;      // 0 none, 1 pipeline, 2 buffered MDU result
   logic        m_stall;
   logic        m_ready;

   task automatic model_reset();
      m_bv = 0; m_brd = '0; m_bd = '0; m_loss = 0; m_force = 0;
      m_we = 1'b0; m_wa = '0; m_wd = '0;
      m_win = 0; m_stall = 1'b0; m_ready = 1'b1;
   endtask

   task automatic model_comb();
      if (m_force)          m_win = 2;
      else if (pipe_valid)  m_win = 1;
      else if (m_bv)        m_win = 2;
      else                  m_win = 0;
      m_stall = m_force && pipe_valid;
      m_ready = !m_bv || (m_win == 2);
   endtask

   task automatic model_edge();
      bit cap;
      cap = mdu_valid && m_ready;
      if (m_win == 1) begin
         m_we = (pipe_rd != 0); m_wa = pipe_rd; m_wd = pipe_wdata;
      end else if (m_win == 2) begin
         m_we = (m_brd != 0); m_wa = m_brd; m_wd = m_bd;
      end else begin
         m_we = 1'b0;
      end
      if (m_win == 2) begin
         m_bv = 0; m_loss = 0; m_force = 0;
      end else if (m_win == 1 && m_bv) begin
         if (m_brd == pipe_rd) begin
            m_bv = 0; m_loss = 0;
         end else begin
            m_loss++;
            if (m_loss == STARVE_LIMIT) m_force = 1;
         end
      end
      if (cap) begin
         m_bv = 1; m_brd = mdu_rd; m_bd = mdu_wdata; m_loss = 0;
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic do_cycle(input string tag);
      #1;
      model_comb();
      chk({tag, ".pipe_stall"}, 32'(pipe_stall), 32'(m_stall));
      chk({tag, ".mdu_ready"},  32'(mdu_ready),  32'(m_ready));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk({tag, ".rf_we"},    32'(rf_we),    32'(m_we));
      chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(m_wa));
      chk({tag, ".rf_wdata"}, rf_wdata,      m_wd);
   endtask

   task automatic set_in(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
      pipe_valid = pv; pipe_rd = prd; pipe_wdata = pd;
      mdu_valid = mv; mdu_rd = mrd; mdu_wdata = md;
   endtask

   task automatic do_reset();
      @(negedge clk);
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      model_reset();
   endtask

   initial begin
      bit hold_pipe;
      bit hold_mdu;

      // Reset state, asserted asynchronously before any clock edge
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      rst_n = 1'b0;
      #2;
      chk("reset.rf_we",      32'(rf_we),      32'd0);
      chk("reset.rf_waddr",   32'(rf_waddr),   32'd0);
      chk("reset.rf_wdata",   rf_wdata,        32'd0);
      chk("reset.pipe_stall", 32'(pipe_stall), 32'd0);
      chk("reset.mdu_ready",  32'(mdu_ready),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // pv prd pd | mv mrd md | stall ready | we waddr wdata
      add(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1, 5'd5,  32'h1234);
      add(1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hCAFE, 1'b0, 1'b1, 1'b0, 5'd5,  32'h1234);
      add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1, 5'd7,  32'hCAFE);
      add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 5'd7,  32'hCAFE);
      add(1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'h9999, 1'b0, 1'b1, 1'b0, 5'd7,  32'hCAFE);
      add(1'b1, 5'd1, 32'h11,   1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b1, 5'd1,  32'h11);
      add(1'b1, 5'd2, 32'h22,   1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b1, 5'd2,  32'h22);
      add(1'b1, 5'd3, 32'h33,   1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b1, 5'd3,  32'h33);
      add(1'b1, 5'd4, 32'h44,   1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b1, 5'd4,  32'h44);
      add(1'b1, 5'd5, 32'h55,   1'b0, 5'd0, 32'h0,    1'b1, 1'b1, 1'b1, 5'd9,  32'h9999);
      add(1'b1, 5'd5, 32'h55,   1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1, 5'd5,  32'h55);
      add(1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'hAAAA, 1'b0, 1'b1, 1'b0, 5'd5,  32'h55);
      add(1'b1, 5'd3, 32'hBBBB, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0, 1'b1, 5'd3,  32'hBBBB);
      add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 5'd3,  32'hBBBB);
      add(1'b1, 5'd0, 32'hFFFF, 1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 5'd0,  32'hFFFF);
      add(1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h5A5A, 1'b0, 1'b1, 1'b0, 5'd0,  32'hFFFF);
      add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 5'd0,  32'h5A5A);
      add(1'b1, 5'd6, 32'h66,   1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1, 5'd6,  32'h66);
      add(1'b0, 5'd0, 32'h0,    1'b1, 5'd10, 32'hA0,  1'b0, 1'b1, 1'b0, 5'd6,  32'h66);
      add(1'b0, 5'd0, 32'h0,    1'b1, 5'd11, 32'hB0,  1'b0, 1'b1, 1'b1, 5'd10, 32'hA0);
      add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b1, 5'd11, 32'hB0);
      add(1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 5'd11, 32'hB0);

      foreach (tbl[i]) begin
         set_in(tbl[i].pv, tbl[i].prd, tbl[i].pd, tbl[i].mv, tbl[i].mrd, tbl[i].md);
         #1;
         chk($sformatf("vec%0d.pipe_stall", i), 32'(pipe_stall), 32'(tbl[i].e_stall));
         chk($sformatf("vec%0d.mdu_ready", i),  32'(mdu_ready),  32'(tbl[i].e_ready));
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("vec%0d.rf_we", i),    32'(rf_we),    32'(tbl[i].e_we));
         chk($sformatf("vec%0d.rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].e_waddr));
         chk($sformatf("vec%0d.rf_wdata", i), rf_wdata,      tbl[i].e_wdata);
      end

      // Randomized traffic against the reference model; stalled WB and
      // refused MDU requests hold their inputs as the protocol requires.
      do_reset();
      hold_pipe = 0;
      hold_mdu  = 0;
      for (int n = 0; n < N_RANDOM; n++) begin
         if (!hold_pipe) begin
            pipe_valid = ($urandom_range(0, 9) < 8);
            pipe_rd    = 5'($urandom_range(0, 7));
            pipe_wdata = $urandom;
         end
         if (!hold_mdu) begin
            mdu_valid = ($urandom_range(0, 9) < 3);
            mdu_rd    = 5'($urandom_range(0, 7));
            mdu_wdata = $urandom;
         end
         do_cycle("rand");
         hold_pipe = pipe_valid && m_stall;
         hold_mdu  = mdu_valid && !m_ready;
      end

      // Reset asserted in the middle of a forced cycle with a full buffer
      do_reset();
      set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999);
      do_cycle("rst_seq.cap");
      for (int k = 1; k <= STARVE_LIMIT; k++) begin
         set_in(1'b1, 5'(k), 32'(k * 16'h1111), 1'b0, 5'd0, 32'd0);
         do_cycle("rst_seq.pipe");
      end
      set_in(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0);
      #1;
      chk("rst_seq.force_stall", 32'(pipe_stall), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid.pipe_stall", 32'(pipe_stall), 32'd0);
      chk("rst_mid.mdu_ready",  32'(mdu_ready),  32'd1);
      chk("rst_mid.rf_we",      32'(rf_we),      32'd0);
      chk("rst_mid.rf_waddr",   32'(rf_waddr),   32'd0);
      chk("rst_mid.rf_wdata",   rf_wdata,        32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      do_cycle("rst_after");
      do_cycle("rst_after2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
